pipeline_stall_controller: RTL

//  Consumes hazard requests and drives every pipeline-register enable/flush plus PC write.

---
 rtl/pipeline_stall_controller_pkg.sv | 35 +++
 rtl/pipeline_stall_controller_sat_counter.sv | 28 ++
 rtl/pipeline_stall_controller.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall controller.
//   state_e      : controller state (run / frozen on data-memory wait)
//   ctrl_t       : bundle of every pipeline-register enable and flush plus PC write
//   CtrlDefault  : enables when no hazard is requested (all writes on, no flush)
//   CtrlFreeze   : everything held, nothing flushed (memory wait and reset)
package pipeline_stall_controller_pkg;

    typedef enum logic {
        StRun    = 1'b0,
        StFreeze = 1'b1
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic mem_wb_write;
    } ctrl_t;

    localparam ctrl_t CtrlDefault = '{
        pc_write:     1'b1,
        if_id_write:  1'b1,
        if_id_flush:  1'b0,
        id_ex_write:  1'b1,
        id_ex_flush:  1'b0,
        ex_mem_write: 1'b1,
        mem_wb_write: 1'b1
    };

    localparam ctrl_t CtrlFreeze = '0;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset, clears count
//   inc    : increment by one this cycle (ignored once saturated)
//   clr    : synchronous clear, wins over inc
//   count  : current value, sticks at all-ones
module pipeline_stall_controller_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller: turns hazard requests into pipeline-register enables/flushes
// and PC write. Priority is reset > mem_busy > branch (incl. deferred) > load-use.
// Ports:
//   clk, rst                 : clock and asynchronous active-low reset
//   load_use_stall           : load-use hazard detected in ID
//   branch_taken             : taken branch/jump resolved in EX this cycle
//   mem_busy                 : data memory cannot complete its access this cycle
//   pc_write .. mem_wb_write : combinational enables/flushes for PC and pipeline registers
//   wait_timeout             : sticky flag, mem_busy held for MAX_WAIT consecutive cycles
//   stall_count, flush_count : saturating counts of load-use bubbles and branch flushes
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_stall,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             wait_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

    state_e           state_q, state_d;
    logic             pend_flush_q, pend_flush_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             wait_timeout_q, wait_timeout_d;
    logic             br_eff;
    logic             inc_stall, inc_flush;
    ctrl_t            ctrl;

    // A branch seen while frozen is remembered and replayed on the first free cycle.
    assign br_eff = branch_taken | pend_flush_q;

    always_comb begin
        ctrl         = CtrlDefault;
        inc_stall    = 1'b0;
        inc_flush    = 1'b0;
        state_d      = StRun;
        pend_flush_d = 1'b0;

        if (mem_busy) begin
            ctrl    = CtrlFreeze;
            state_d = StFreeze;
            unique case (state_q)
                StRun:    pend_flush_d = br_eff;
                StFreeze: pend_flush_d = pend_flush_q | branch_taken;
                default:  pend_flush_d = 1'b0;
            endcase
        end else if (br_eff) begin
            // Load-use is on the wrong path here and is dropped.
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            inc_flush        = 1'b1;
        end else if (load_use_stall) begin
            ctrl.pc_write    = 1'b0;
            ctrl.if_id_write = 1'b0;
            ctrl.id_ex_flush = 1'b1;
            inc_stall        = 1'b1;
        end

        if (!rst) begin
            ctrl = CtrlFreeze;
        end
    end

    always_comb begin
        wait_cnt_d     = '0;
        wait_timeout_d = wait_timeout_q;
        if (mem_busy) begin
            wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + WaitW'(1);
            if (wait_cnt_d == WaitMax) begin
                wait_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StRun;
            pend_flush_q   <= 1'b0;
            wait_cnt_q     <= '0;
            wait_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pend_flush_q   <= pend_flush_d;
            wait_cnt_q     <= wait_cnt_d;
            wait_timeout_q <= wait_timeout_d;
        end
    end

    pipeline_stall_controller_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_stall),
        .clr   (1'b0),
        .count (stall_count)
    );

    pipeline_stall_controller_sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_flush),
        .clr   (1'b0),
        .count (flush_count)
    );

    assign pc_write     = ctrl.pc_write;
    assign if_id_write  = ctrl.if_id_write;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_write  = ctrl.id_ex_write;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_write = ctrl.ex_mem_write;
    assign mem_wb_write = ctrl.mem_wb_write;
    assign wait_timeout = wait_timeout_q;

endmodule
